phase_shift_ctrl: RTL and testbench
===================================

# phase_shift_ctrl

Sequencer for the DCM variable-phase-shift port that drives the sampling clock. It accepts a signed target phase and a load strobe from the register interface (PHASE_ADDR1/PHASE_ADDR2 writes). It then issues single-step PSEN/PSINCDEC requests to the DCM until the tracked phase equals the target. It reports the current phase, a done flag and a sticky timeout error back for readout.

## Interface
- PHASE_WIDTH, 9: width of target and current phase, two's complement.
- PHASE_MAX, 255: magnitude clamp applied to targets; must be ≤ 2^(PHASE_WIDTH-1)-1.
- PS_TIMEOUT, 1023: maximum cycles to wait for psdone_i after a step.
- clk  in  1  system clock; every register in the block is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- target_i  in  PHASE_WIDTH  signed requested phase; sampled only when load_i=1.
- load_i  in  1  single-cycle strobe that latches target_i.
- dcm_locked_i  in  1  DCM LOCKED; no step is issued while it is 0.
- dcm_rst_i  in  1  DCM is being reset; the phase shift returns to 0.
- psdone_i  in  1  DCM PSDONE, a one-cycle pulse.
- psen_o  out  1  DCM PSEN, a one-cycle pulse per step.
- psincdec_o  out  1  DCM PSINCDEC: 1 = increment, 0 = decrement; valid while psen_o=1.
- current_o  out  PHASE_WIDTH  signed phase currently applied.
- busy_o  out  1  a sequence is in progress.
- done_o  out  1  target reached since the last load.
- error_o  out  1  sticky psdone timeout.

## Operation
- States: IDLE, CHECK, STEP, WAIT, ERR.
- Reset values: state IDLE, psen_o=0, psincdec_o=0, current_o=0, target register=0, busy_o=0, done_o=0, error_o=0, timeout counter=0.
- IDLE:
  - load_i=1: latch clamp(target_i), clear done_o and error_o, go to CHECK.
- CHECK:
  - target==current: set done_o, go to IDLE.
  - Otherwise, if dcm_locked_i=0: stay in CHECK.
  - Otherwise: go to STEP, with psincdec_o = (target > current), signed compare.
- STEP: psen_o=1 for exactly this cycle; clear the counter; go to WAIT.
- WAIT:
  - psdone_i=1: current ±1 according to psincdec_o, go to CHECK.
  - Counter reaches PS_TIMEOUT without psdone_i: set error_o, go to ERR; current_o unchanged.
- ERR:
  - Hold. load_i behaves as in IDLE; error_o clears on that load.
- busy_o=1 in CHECK, STEP and WAIT.
- Clamp: values > PHASE_MAX become PHASE_MAX; values < -PHASE_MAX become -PHASE_MAX.
  - With default parameters, -256 becomes -255.
- load_i in CHECK, STEP or WAIT:
  - Replaces the target register and clears done_o.
  - Does not abort an outstanding step; the new target takes effect at the next CHECK.
- psdone_i outside WAIT is ignored.
- dcm_rst_i=1, any state: current_o←0, psen_o←0, done_o←0, state←IDLE.
  - Target and error_o are retained.
  - dcm_rst_i has priority over load_i and psdone_i in the same cycle.
- reset has priority over everything.
- current_o never exceeds ±PHASE_MAX, so there is no wrap-around.

## Timing
- All outputs are registered.
- load_i high in cycle N:
  - Target latched, state=CHECK at N+1.
  - If a step is needed, psen_o=1 during N+2.
- psdone_i high in cycle M during WAIT:
  - current_o updated and state=CHECK at M+1.
  - Next psen_o at M+2.
- Per-step overhead is 2 cycles plus DCM latency.
- Target already equal at CHECK in cycle K: done_o=1 and busy_o=0 from K+1.
  - A load of the current value therefore completes in 2 cycles.
- Timeout: error_o rises PS_TIMEOUT+1 cycles after the psen_o cycle.
- psincdec_o holds its value from STEP until the next STEP.

## Test plan
- Reset, load target=+3; DCM model pulses psdone 5 cycles after each psen -> 3 psen pulses with psincdec=1; current_o steps 1,2,3; done_o=1, busy_o=0; error_o=0.
- From current=+3, load target=-2 -> 5 psen pulses with psincdec=0; current_o ends at -2 (9'h1FE); done_o=1.
- Load target=-256 -> latched -255, 255 decrement steps. Load +255 from -255 -> 510 increments, final 255; no overflow.
- DCM model never returns psdone -> psen once; error_o=1 at PS_TIMEOUT+1 cycles after it; busy_o=0; current_o unchanged. A subsequent load clears error_o and stepping resumes.
- dcm_locked_i=0 at load -> no psen, busy_o=1 held in CHECK; raise locked -> psen within 2 cycles. Mid-sequence load of a new target -> the outstanding step completes, then the direction follows the new target.
- dcm_rst_i asserted in WAIT with current=+2 -> next cycle current_o=0, psen_o=0, busy_o=0, done_o=0. A psdone arriving afterwards does not change current_o. Reset mid-sequence -> all outputs return to reset values.

Source files
------------

// File: rtl/phase_shift_ctrl.sv
// Phase-shift sequencer for the DCM variable-phase port: walks the applied
// phase one PSEN step at a time toward a clamped signed target.
module phase_shift_ctrl #(
    parameter int PHASE_WIDTH = 9,
    parameter int PHASE_MAX   = 255,
    parameter int PS_TIMEOUT  = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PHASE_WIDTH-1:0] target_i,
    input  logic                   load_i,
    input  logic                   dcm_locked_i,
    input  logic                   dcm_rst_i,
    input  logic                   psdone_i,
    output logic                   psen_o,
    output logic                   psincdec_o,
    output logic [PHASE_WIDTH-1:0] current_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [2:0]             state_o
);

    localparam int CNT_W = $clog2(PS_TIMEOUT + 1);
    localparam logic signed [PHASE_WIDTH-1:0] POS_LIM  = PHASE_WIDTH'(PHASE_MAX);
    localparam logic signed [PHASE_WIDTH-1:0] NEG_LIM  = PHASE_WIDTH'(-PHASE_MAX);
    localparam logic signed [PHASE_WIDTH-1:0] ONE      = PHASE_WIDTH'(1);
    localparam logic [CNT_W-1:0]              CNT_LAST = CNT_W'(PS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]              CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_STEP  = 3'd2,
        S_WAIT  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic signed [PHASE_WIDTH-1:0]  target_q, target_d;
    logic signed [PHASE_WIDTH-1:0]  current_q, current_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           psen_q, psen_d;
    logic                           psincdec_q, psincdec_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           error_q, error_d;

    logic signed [PHASE_WIDTH-1:0]  target_s;
    logic signed [PHASE_WIDTH-1:0]  target_clamped;
    logic                           at_target;
    logic                           step_up;
    logic                           timed_out;

    assign target_s  = $signed(target_i);
    assign at_target = (target_q == current_q);
    assign step_up   = (target_q > current_q);
    assign timed_out = (cnt_q == CNT_LAST) && !psdone_i;

    always_comb begin
        target_clamped = target_s;
        if (target_s > POS_LIM) begin
            target_clamped = POS_LIM;
        end else if (target_s < NEG_LIM) begin
            target_clamped = NEG_LIM;
        end
    end

    // State register and all datapath/output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            current_q  <= '0;
            cnt_q      <= '0;
            psen_q     <= 1'b0;
            psincdec_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            current_q  <= current_d;
            cnt_q      <= cnt_d;
            psen_q     <= psen_d;
            psincdec_q <= psincdec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // A load landing in CHECK re-evaluates against the new target next cycle
    // instead of declaring done against the stale one.
    always_comb begin
        state_d = state_q;
        if (dcm_rst_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (load_i) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (load_i)            state_d = S_CHECK;
                    else if (at_target)    state_d = S_IDLE;
                    else if (dcm_locked_i) state_d = S_STEP;
                end
                S_STEP: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (psdone_i)       state_d = S_CHECK;
                    else if (timed_out) state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        target_d   = target_q;
        current_d  = current_q;
        cnt_d      = cnt_q;
        psincdec_d = psincdec_q;
        done_d     = done_q;
        error_d    = error_q;
        psen_d     = (state_d == S_STEP);
        busy_d     = (state_d == S_CHECK) || (state_d == S_STEP) || (state_d == S_WAIT);

        if (dcm_rst_i) begin
            // DCM reset returns the physical shift to zero; target and error survive.
            current_d = '0;
            cnt_d     = '0;
            done_d    = 1'b0;
        end else begin
            if (load_i) begin
                target_d = target_clamped;
                done_d   = 1'b0;
                error_d  = 1'b0;
            end
            case (state_q)
                S_CHECK: begin
                    if (state_d == S_IDLE) done_d = 1'b1;
                    if (state_d == S_STEP) psincdec_d = step_up;
                end
                S_STEP: begin
                    cnt_d = '0;
                end
                S_WAIT: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (psdone_i) begin
                        current_d = psincdec_q ? (current_q + ONE) : (current_q - ONE);
                    end else if (timed_out) begin
                        error_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign psen_o     = psen_q;
    assign psincdec_o = psincdec_q;
    assign current_o  = current_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign state_o    = state_q;

    a_psen_single: assert property (@(posedge clk) disable iff (reset) psen_q |=> !psen_q);
    a_psen_busy:   assert property (@(posedge clk) disable iff (reset) psen_q |-> busy_q);
    a_phase_range: assert property (@(posedge clk) disable iff (reset)
                                    (current_q <= POS_LIM) && (current_q >= NEG_LIM));

endmodule

// File: tb/tb_phase_shift_ctrl.sv
// Directed bench for phase_shift_ctrl with a small DCM model that answers
// each PSEN with a PSDONE pulse a fixed number of cycles later.
module tb_phase_shift_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] target_i;
  logic       load_i;
  logic       dcm_locked_i;
  logic       dcm_rst_i;
  logic       psdone_i;
  logic       psen_o;
  logic       psincdec_o;
  logic [8:0] current_o;
  logic       busy_o;
  logic       done_o;
  logic       error_o;
  logic [2:0] state_o;

  logic dcm_psdone = 1'b0;
  logic tb_psdone;
  logic dcm_respond;
  int   dly = 0;
  int   inc_n = 0;
  int   dec_n = 0;
  int   errors = 0;
  int   checks = 0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  assign psdone_i = dcm_psdone | tb_psdone;

  phase_shift_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .target_i     (target_i),
    .load_i       (load_i),
    .dcm_locked_i (dcm_locked_i),
    .dcm_rst_i    (dcm_rst_i),
    .psdone_i     (psdone_i),
    .psen_o       (psen_o),
    .psincdec_o   (psincdec_o),
    .current_o    (current_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // DCM model: PSDONE five negedges after each observed PSEN, counted by direction.
  always @(negedge clk) begin
    dcm_psdone = 1'b0;
    if (dly > 0) begin
      dly = dly - 1;
      if (dly == 0 && dcm_respond) dcm_psdone = 1'b1;
    end
    if (psen_o === 1'b1) begin
      dly = 5;
      if (psincdec_o) inc_n = inc_n + 1;
      else dec_n = dec_n + 1;
    end
  end

  task automatic do_load(input logic [8:0] t);
    @(negedge clk);
    target_i = t;
    load_i   = 1'b1;
    @(negedge clk);
    load_i   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy_o === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%b after %0d cycles, required 0", busy_o, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (psen_o !== 1'b0) begin errors++; $display("FAIL rst_psen got=%b exp=0", psen_o); end
    checks++; if (psincdec_o !== 1'b0) begin errors++; $display("FAIL rst_psincdec got=%b exp=0", psincdec_o); end
    checks++; if (current_o !== 9'h000) begin errors++; $display("FAIL rst_current got=%h exp=000", current_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL rst_error got=%b exp=0", error_o); end
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=0", state_o); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy_o !== 1'b0 || state_o !== ST_IDLE) begin errors++; $display("FAIL rst_release busy=%b state=%0d exp 0/0", busy_o, state_o); end
  endtask

  task automatic test_increment;
    int bi, bd;
    bi = inc_n; bd = dec_n;
    do_load(9'h003);
    checks++; if (busy_o !== 1'b1 || state_o !== ST_CHECK) begin errors++; $display("FAIL inc_check busy=%b state=%0d exp 1/1", busy_o, state_o); end
    @(negedge clk);
    checks++; if (psen_o !== 1'b1 || psincdec_o !== 1'b1) begin errors++; $display("FAIL inc_first_psen psen=%b dir=%b exp 1/1", psen_o, psincdec_o); end
    wait_idle(200);
    checks++; if (inc_n - bi !== 3 || dec_n - bd !== 0) begin errors++; $display("FAIL inc_steps inc=%0d dec=%0d exp 3/0", inc_n - bi, dec_n - bd); end
    checks++; if (current_o !== 9'h003) begin errors++; $display("FAIL inc_current got=%h exp=003", current_o); end
    checks++; if (done_o !== 1'b1 || error_o !== 1'b0) begin errors++; $display("FAIL inc_flags done=%b err=%b exp 1/0", done_o, error_o); end
  endtask

  task automatic test_decrement;
    int bi, bd;
    bi = inc_n; bd = dec_n;
    do_load(9'h1FE);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL dec_done_clear got=%b exp=0", done_o); end
    @(negedge clk);
    checks++; if (psen_o !== 1'b1 || psincdec_o !== 1'b0) begin errors++; $display("FAIL dec_first_psen psen=%b dir=%b exp 1/0", psen_o, psincdec_o); end
    wait_idle(200);
    checks++; if (dec_n - bd !== 5 || inc_n - bi !== 0) begin errors++; $display("FAIL dec_steps dec=%0d inc=%0d exp 5/0", dec_n - bd, inc_n - bi); end
    checks++; if (current_o !== 9'h1FE || done_o !== 1'b1) begin errors++; $display("FAIL dec_final cur=%h done=%b exp 1FE/1", current_o, done_o); end
  endtask

  task automatic test_dcm_rst;
    int n;
    do_load(9'h003);
    n = 0;
    while (!(psen_o === 1'b1 && current_o === 9'h002) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (current_o !== 9'h002) begin errors++; $display("FAIL drst_reach cur=%h exp=002", current_o); end
    @(negedge clk);
    checks++; if (state_o !== ST_WAIT) begin errors++; $display("FAIL drst_wait state=%0d exp=3", state_o); end
    dcm_rst_i = 1'b1;
    @(negedge clk);
    dcm_rst_i = 1'b0;
    checks++; if (current_o !== 9'h000) begin errors++; $display("FAIL drst_current got=%h exp=000", current_o); end
    checks++; if (psen_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL drst_flags psen=%b busy=%b done=%b exp 0/0/0", psen_o, busy_o, done_o); end
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL drst_state got=%0d exp=0", state_o); end
    repeat (8) @(negedge clk);
    checks++; if (current_o !== 9'h000) begin errors++; $display("FAIL drst_late_psdone cur=%h exp=000", current_o); end
    tb_psdone = 1'b1;
    @(negedge clk);
    tb_psdone = 1'b0;
    @(negedge clk);
    checks++; if (current_o !== 9'h000 || state_o !== ST_IDLE) begin errors++; $display("FAIL drst_stray_psdone cur=%h state=%0d exp 000/0", current_o, state_o); end
  endtask

  task automatic test_clamp;
    int bi, bd;
    bi = inc_n; bd = dec_n;
    do_load(9'h100);
    @(negedge clk);
    checks++; if (psen_o !== 1'b1 || psincdec_o !== 1'b0) begin errors++; $display("FAIL clamp_dir psen=%b dir=%b exp 1/0", psen_o, psincdec_o); end
    wait_idle(3000);
    checks++; if (dec_n - bd !== 255) begin errors++; $display("FAIL clamp_neg_steps got=%0d exp=255", dec_n - bd); end
    checks++; if (current_o !== 9'h101 || done_o !== 1'b1) begin errors++; $display("FAIL clamp_neg_final cur=%h done=%b exp 101/1", current_o, done_o); end
    do_load(9'h0FF);
    wait_idle(6000);
    checks++; if (inc_n - bi !== 510) begin errors++; $display("FAIL clamp_pos_steps got=%0d exp=510", inc_n - bi); end
    checks++; if (current_o !== 9'h0FF || done_o !== 1'b1 || error_o !== 1'b0) begin errors++; $display("FAIL clamp_pos_final cur=%h done=%b err=%b exp 0FF/1/0", current_o, done_o, error_o); end
  endtask

  task automatic test_equal_load;
    int bi, bd;
    bi = inc_n; bd = dec_n;
    do_load(9'h0FF);
    checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL eq_check busy=%b done=%b exp 1/0", busy_o, done_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || state_o !== ST_IDLE) begin errors++; $display("FAIL eq_done done=%b busy=%b state=%0d exp 1/0/0", done_o, busy_o, state_o); end
    checks++; if (inc_n - bi + dec_n - bd !== 0) begin errors++; $display("FAIL eq_no_step steps=%0d exp=0", inc_n - bi + dec_n - bd); end
  endtask

  task automatic test_timeout;
    int bi, bd;
    bi = inc_n; bd = dec_n;
    dcm_respond = 1'b0;
    do_load(9'h0FA);
    @(negedge clk);
    checks++; if (psen_o !== 1'b1 || psincdec_o !== 1'b0) begin errors++; $display("FAIL to_psen psen=%b dir=%b exp 1/0", psen_o, psincdec_o); end
    repeat (1023) @(negedge clk);
    checks++; if (error_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL to_early err=%b busy=%b exp 0/1", error_o, busy_o); end
    @(negedge clk);
    checks++; if (error_o !== 1'b1 || busy_o !== 1'b0 || state_o !== ST_ERR) begin errors++; $display("FAIL to_fire err=%b busy=%b state=%0d exp 1/0/4", error_o, busy_o, state_o); end
    checks++; if (current_o !== 9'h0FF || (inc_n - bi + dec_n - bd) !== 1) begin errors++; $display("FAIL to_hold cur=%h steps=%0d exp 0FF/1", current_o, inc_n - bi + dec_n - bd); end
    dcm_respond = 1'b1;
    do_load(9'h0FD);
    checks++; if (error_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL to_reload err=%b busy=%b exp 0/1", error_o, busy_o); end
    wait_idle(200);
    checks++; if (current_o !== 9'h0FD || done_o !== 1'b1 || error_o !== 1'b0) begin errors++; $display("FAIL to_resume cur=%h done=%b err=%b exp 0FD/1/0", current_o, done_o, error_o); end
  endtask

  task automatic test_locked_and_retarget;
    int bi, bd;
    bi = inc_n; bd = dec_n;
    dcm_locked_i = 1'b0;
    do_load(9'h0FA);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (psen_o !== 1'b0 || busy_o !== 1'b1 || state_o !== ST_CHECK) begin errors++; $display("FAIL lock_hold%0d psen=%b busy=%b state=%0d exp 0/1/1", i, psen_o, busy_o, state_o); end
    end
    dcm_locked_i = 1'b1;
    @(negedge clk);
    checks++; if (psen_o !== 1'b1 || psincdec_o !== 1'b0) begin errors++; $display("FAIL lock_release psen=%b dir=%b exp 1/0", psen_o, psincdec_o); end
    @(negedge clk);
    target_i = 9'h0FF;
    load_i   = 1'b1;
    @(negedge clk);
    load_i   = 1'b0;
    wait_idle(200);
    checks++; if (dec_n - bd !== 1 || inc_n - bi !== 3) begin errors++; $display("FAIL retarget_steps dec=%0d inc=%0d exp 1/3", dec_n - bd, inc_n - bi); end
    checks++; if (current_o !== 9'h0FF || done_o !== 1'b1) begin errors++; $display("FAIL retarget_final cur=%h done=%b exp 0FF/1", current_o, done_o); end
  endtask

  task automatic test_reset_mid;
    do_load(9'h0FA);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (psen_o !== 1'b0 || psincdec_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL mrst_ctl psen=%b dir=%b busy=%b exp 0/0/0", psen_o, psincdec_o, busy_o); end
    checks++; if (current_o !== 9'h000 || done_o !== 1'b0 || error_o !== 1'b0 || state_o !== ST_IDLE) begin errors++; $display("FAIL mrst_state cur=%h done=%b err=%b state=%0d exp 000/0/0/0", current_o, done_o, error_o, state_o); end
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (current_o !== 9'h000 || busy_o !== 1'b0) begin errors++; $display("FAIL mrst_after cur=%h busy=%b exp 000/0", current_o, busy_o); end
  endtask

  initial begin
    reset        = 1'b1;
    target_i     = 9'h000;
    load_i       = 1'b0;
    dcm_locked_i = 1'b1;
    dcm_rst_i    = 1'b0;
    tb_psdone    = 1'b0;
    dcm_respond  = 1'b1;
    repeat (2) @(negedge clk);
    test_reset;
    test_increment;
    test_decrement;
    test_dcm_rst;
    test_clamp;
    test_equal_load;
    test_timeout;
    test_locked_and_retarget;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
